// File: rtl/pipeline_stall_sequencer_if.sv
// ----------------------------------------------------------------------------
// pipeline_stall_sequencer_if
//   Bundles the hazard/redirect/interrupt requests going into the stall
//   sequencer and the pipeline-register controls coming back out of it.
//   master : pipeline side (drives requests, consumes controls)
//   slave  : sequencer side (consumes requests, drives controls)
//   Requests : load_use_stall, pop_stall, branch_taken_ex, mem_busy, int_req
//   Controls : pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
//              int_push_pc, int_push_flags, int_vector_sel, int_ack,
//              stall_count[CNT_W-1:0]
// ----------------------------------------------------------------------------
interface pipeline_stall_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             load_use_stall;
  logic             pop_stall;
  logic             branch_taken_ex;
  logic             mem_busy;
  logic             int_req;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             int_push_pc;
  logic             int_push_flags;
  logic             int_vector_sel;
  logic             int_ack;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output load_use_stall, pop_stall, branch_taken_ex, mem_busy, int_req,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
           int_push_pc, int_push_flags, int_vector_sel, int_ack, stall_count
  );

  modport slave (
    input  load_use_stall, pop_stall, branch_taken_ex, mem_busy, int_req,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
           int_push_pc, int_push_flags, int_vector_sel, int_ack, stall_count
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_stall_sequencer
//   Central stall/flush/interrupt sequencer for the 5-stage pipeline.
//   Resolves hazard stalls, execute redirects and memory-busy freezes, runs
//   the interrupt entry sequence (drain, push PC, push flags, vector) and
//   counts cycles in which the PC did not advance.
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : pipeline_stall_sequencer_if.slave (requests in, controls out)
//   Control outputs are combinational on state + requests; stall_count is
//   registered and saturates at all-ones.
// ----------------------------------------------------------------------------
module pipeline_stall_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_stall_sequencer_if.slave     bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PUSH_PC,
    ST_PUSH_FLAGS,
    ST_VECTOR
  } state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
  logic [CNT_W-1:0] stall_count_reg;

  logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en;
  logic int_push_pc, int_push_flags, int_vector_sel, int_ack;

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    exmem_en       = 1'b0;
    // Interrupt strobes follow the state alone, so a memory freeze holds
    // them at whatever the frozen state is presenting.
    int_push_pc    = (state_reg == ST_PUSH_PC);
    int_push_flags = (state_reg == ST_PUSH_FLAGS);
    int_vector_sel = (state_reg == ST_VECTOR);
    int_ack        = (state_reg == ST_VECTOR);

    if (rst) begin
      ifid_flush     = 1'b1;
      idex_bubble    = 1'b1;
      int_push_pc    = 1'b0;
      int_push_flags = 1'b0;
      int_vector_sel = 1'b0;
      int_ack        = 1'b0;
    end else if (bus.mem_busy) begin
      // Whole pipe frozen: enables, flush and bubble all low, FSM holds.
    end else begin
      case (state_reg)
        ST_RUN: begin
          exmem_en = 1'b1;
          if (bus.branch_taken_ex) begin
            // Redirect wins over any stall: the stalled decode instruction
            // is on the wrong path and gets flushed anyway.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (bus.load_use_stall || bus.pop_stall) begin
            idex_bubble = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            if (bus.int_req) begin
              state_next     = ST_DRAIN;
              drain_cnt_next = DW'(DRAIN_CYCLES - 1);
            end
          end
        end
        ST_DRAIN: begin
          // Let older instructions retire; new fetches are squashed. A
          // redirect still updates the PC so it holds the return address.
          pc_en       = bus.branch_taken_ex;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          if (drain_cnt_reg == '0) begin
            state_next = ST_PUSH_PC;
          end else begin
            drain_cnt_next = drain_cnt_reg - DW'(1);
          end
        end
        ST_PUSH_PC: begin
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          state_next  = ST_PUSH_FLAGS;
        end
        ST_PUSH_FLAGS: begin
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          state_next  = ST_VECTOR;
        end
        ST_VECTOR: begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          state_next  = ST_RUN;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      drain_cnt_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      if (!pc_en && (stall_count_reg != {CNT_W{1'b1}})) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en          = pc_en;
  assign bus.ifid_en        = ifid_en;
  assign bus.ifid_flush     = ifid_flush;
  assign bus.idex_bubble    = idex_bubble;
  assign bus.exmem_en       = exmem_en;
  assign bus.int_push_pc    = int_push_pc;
  assign bus.int_push_flags = int_push_flags;
  assign bus.int_vector_sel = int_vector_sel;
  assign bus.int_ack        = int_ack;
  assign bus.stall_count    = stall_count_reg;

endmodule
